aes128_sched: RTL and testbench

Round-robin scheduler that shares one AES-128 core among `NREQ` requesters (e.g. the Wishbone register front-end and the logic-analyzer path) inside the user project area. It accepts one key/block/direction command at a time and launches the core with a single-cycle start pulse. It waits for the core's done strobe, with an optional watchdog, and returns the result to the requester that issued the command. All logic runs in the Wishbone clock domain.

---
 rtl/aes128_sched_if.sv | 37 +++
 rtl/aes128_sched.sv | 110 +++++++++++
 tb/tb_aes128_sched.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes128_sched_if.sv
// Requester-side and core-side bundle of the AES-128 scheduler.
// The slave view belongs to the scheduler; the master view is the surrounding logic.
interface aes128_sched_if #(
  parameter int NREQ = 2
);
  localparam int GW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0][127:0] req_key;
  logic [NREQ-1:0][127:0] req_block;
  logic [NREQ-1:0]        req_decrypt;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [127:0]           rsp_data;
  logic                   rsp_err;
  logic                   core_start;
  logic [127:0]           core_key;
  logic [127:0]           core_block;
  logic                   core_decrypt;
  logic                   core_done;
  logic [127:0]           core_result;
  logic                   busy;
  logic [GW-1:0]          grant_id;

  modport slave (
    input  req_valid, req_key, req_block, req_decrypt, rsp_ready, core_done, core_result,
    output req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_key, core_block,
           core_decrypt, busy, grant_id
  );

  modport master (
    output req_valid, req_key, req_block, req_decrypt, rsp_ready, core_done, core_result,
    input  req_ready, rsp_valid, rsp_data, rsp_err, core_start, core_key, core_block,
           core_decrypt, busy, grant_id
  );
endinterface

// File: rtl/aes128_sched.sv
// Round-robin arbiter sharing one AES-128 core among NREQ requesters,
// with a start pulse, optional done watchdog and per-requester response return.
module aes128_sched #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 64
) (
  input logic           wb_clk_i,
  input logic           wb_rst_i,
  aes128_sched_if.slave bus
);
  localparam int GW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr, win, idx, grant_id;
  logic            win_vld, timeout_hit, rsp_hs;
  logic [CW-1:0]   cnt;
  logic [127:0]    key_q, block_q, data_q;
  logic            dec_q, err_q;

  // first valid requester at or after rr_ptr, wrapping
  always_comb begin
    win     = '0;
    idx     = '0;
    win_vld = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = GW'((int'(rr_ptr) + k) % NREQ);
      if (!win_vld && bus.req_valid[idx]) begin
        win_vld = 1'b1;
        win     = idx;
      end
    end
  end

  // counter value after this WAIT cycle would be TIMEOUT-1
  assign timeout_hit = (TIMEOUT != 0) && (int'(cnt) + 1 >= TIMEOUT - 1);
  assign rsp_hs      = bus.rsp_ready[grant_id];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_vld) state_nxt = START;
      START:   state_nxt = WAIT;
      WAIT:    if (bus.core_done || timeout_hit) state_nxt = RESP;
      RESP:    if (rsp_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = '0;
    bus.rsp_valid  = '0;
    if (state == IDLE && win_vld) bus.req_ready = ONE << win;
    if (state == RESP)            bus.rsp_valid = ONE << grant_id;
    bus.core_start = (state == START);
    bus.busy       = (state != IDLE);
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      key_q    <= '0;
      block_q  <= '0;
      dec_q    <= 1'b0;
      grant_id <= '0;
      rr_ptr   <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (win_vld) begin
          key_q    <= bus.req_key[win];
          block_q  <= bus.req_block[win];
          dec_q    <= bus.req_decrypt[win];
          grant_id <= win;
        end
        START: cnt <= '0;
        WAIT: begin
          if (cnt != {CW{1'b1}}) cnt <= cnt + 1'b1;
          // a done in the expiry cycle still delivers the real result
          if (bus.core_done) begin
            data_q <= bus.core_result;
            err_q  <= 1'b0;
          end else if (timeout_hit) begin
            data_q <= '0;
            err_q  <= 1'b1;
          end
        end
        RESP: if (rsp_hs)
          rr_ptr <= (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;
        default: ;
      endcase
    end
  end

  assign bus.core_key     = key_q;
  assign bus.core_block   = block_q;
  assign bus.core_decrypt = dec_q;
  assign bus.rsp_data     = data_q;
  assign bus.rsp_err      = err_q;
  assign bus.grant_id     = grant_id;
endmodule

// File: tb/tb_aes128_sched.sv
// Bench for aes128_sched: dut_a (TIMEOUT 64) behind an 11-cycle core model,
// dut_b (TIMEOUT 8) with a hand-driven core_done for watchdog cases.
module tb_aes128_sched;
  localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes128_sched_if #(.NREQ(2)) ia ();
  aes128_sched_if #(.NREQ(2)) ib ();

  aes128_sched #(.NREQ(2), .TIMEOUT(64)) dut_a (.wb_clk_i(clk), .wb_rst_i(rst), .bus(ia));
  aes128_sched #(.NREQ(2), .TIMEOUT(8))  dut_b (.wb_clk_i(clk), .wb_rst_i(rst), .bus(ib));

  int errors = 0;
  int checks = 0;
  int starts_a = 0;
  int cd = 0;
  int rr = 0;
  logic [127:0] ck [2];
  logic [127:0] cb [2];
  logic         cdec [2];

  // stand-in cipher: the known FIPS-197 pair, otherwise an involutive mix
  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] b,
                                          input logic dec);
    if (k == KEY && b == PT && !dec) return CT;
    if (k == KEY && b == CT && dec)  return PT;
    return b ^ {k[63:0], k[127:64]} ^ 128'h5a5a_a5a5_0f0f_f0f0_3c3c_c3c3_9696_6969;
  endfunction

  // core model for dut_a: done high 11 cycles after the start pulse
  always @(posedge clk) begin
    ia.core_done <= 1'b0;
    if (rst) cd <= 0;
    else if (ia.core_start) begin
      cd       <= 11;
      starts_a <= starts_a + 1;
    end else if (cd != 0) begin
      cd <= cd - 1;
      if (cd == 2) begin
        ia.core_done   <= 1'b1;
        ia.core_result <= cipher(ia.core_key, ia.core_block, ia.core_decrypt);
      end
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input int i, input logic [127:0] k, input logic [127:0] b, input logic d);
    ck[i] = k; cb[i] = b; cdec[i] = d;
    ia.req_key[i] = k; ia.req_block[i] = b; ia.req_decrypt[i] = d;
  endtask

  task automatic rnd(input int i);
    load(i, {$urandom(), $urandom(), $urandom(), $urandom()},
         {$urandom(), $urandom(), $urandom(), $urandom()}, 1'($urandom_range(0, 1)));
  endtask

  // one command on dut_a, from the IDLE cycle through the response handshake
  task automatic txn(input logic [1:0] vmask, input int hold);
    int g, lat;
    logic [1:0] m;
    logic [127:0] exp, ekey, eblk, d0;
    logic edec, bad;
    g = -1;
    for (int k = 0; k < 2; k++)
      if (g < 0 && vmask[(rr + k) % 2]) g = (rr + k) % 2;
    m = 2'b01 << g;
    exp = cipher(ck[g], cb[g], cdec[g]);
    ekey = ck[g]; eblk = cb[g]; edec = cdec[g];
    ia.req_valid = vmask;
    #1;
    chk("req_ready", ia.req_ready, m);
    @(negedge clk);
    chk("core_start", ia.core_start, 1'b1);
    chk("grant_id", ia.grant_id, g);
    chk("core_key", ia.core_key, ekey);
    chk("core_block", ia.core_block, eblk);
    rnd(g);
    lat = 0; bad = 1'b0;
    while (ia.rsp_valid == 2'b00 && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ia.req_ready != 2'b00 || ia.core_key !== ekey || ia.core_decrypt !== edec) bad = 1'b1;
    end
    chk("latency", lat, 12);
    chk("rsp_valid", ia.rsp_valid, m);
    chk("rsp_data", ia.rsp_data, exp);
    chk("rsp_err", ia.rsp_err, 1'b0);
    chk("grant_at_rsp", ia.grant_id, g);
    d0 = ia.rsp_data;
    ia.rsp_ready = ~m;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (ia.rsp_valid !== m || ia.rsp_data !== d0 || ia.req_ready != 2'b00) bad = 1'b1;
    end
    chk("op_stable", bad, 1'b0);
    ia.rsp_ready = m;
    @(negedge clk);
    ia.rsp_ready = 2'b00;
    chk("rsp_once", ia.rsp_valid, 2'b00);
    rr = (g + 1) % 2;
  endtask

  initial begin
    logic [127:0] r;
    logic bad;
    int lat, s0;
    ia.req_valid = '0; ia.req_key = '0; ia.req_block = '0; ia.req_decrypt = '0;
    ia.rsp_ready = '0;
    ib.req_valid = '0; ib.req_key = '0; ib.req_block = '0; ib.req_decrypt = '0;
    ib.rsp_ready = '0; ib.core_done = 1'b0; ib.core_result = '0;
    load(0, '0, '0, 1'b0); load(1, '0, '0, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_busy", ia.busy, 1'b0);
    chk("rst_req_ready", ia.req_ready, 2'b00);
    chk("rst_rsp_valid", ia.rsp_valid, 2'b00);
    chk("rst_core_start", ia.core_start, 1'b0);
    chk("rst_core_key", ia.core_key, '0);
    chk("rst_grant", ia.grant_id, 1'b0);
    chk("rst_rsp_data", ia.rsp_data, '0);

    // single encrypt, requester 0
    s0 = starts_a;
    load(0, KEY, PT, 1'b0);
    txn(2'b01, 0);
    chk("start_pulses", starts_a - s0, 1);

    // decrypt round trip, requester 1
    ia.req_valid = 2'b00;
    load(1, KEY, CT, 1'b1);
    txn(2'b10, 0);

    // fairness with both requesters busy, one long backpressure episode
    rnd(0); rnd(1);
    for (int i = 0; i < 6; i++) txn(2'b11, (i == 2) ? 20 : int'($urandom_range(0, 2)));

    // random request patterns
    for (int i = 0; i < 8; i++) begin
      logic [1:0] vm;
      vm = 2'($urandom_range(1, 3));
      txn(vm, int'($urandom_range(0, 3)));
    end

    // reset during WAIT
    ia.req_valid = 2'b00;
    rnd(0);
    ia.req_valid = 2'b01;
    @(negedge clk);
    ia.req_valid = 2'b00;
    repeat (2) @(negedge clk);
    chk("pre_rst_busy", ia.busy, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", ia.busy, 1'b0);
    chk("mid_rst_core_key", ia.core_key, '0);
    chk("mid_rst_core_block", ia.core_block, '0);
    chk("mid_rst_core_dec", ia.core_decrypt, 1'b0);
    chk("mid_rst_rsp_data", ia.rsp_data, '0);
    chk("mid_rst_rsp_err", ia.rsp_err, 1'b0);
    chk("mid_rst_grant", ia.grant_id, 1'b0);
    chk("mid_rst_rsp_valid", ia.rsp_valid, 2'b00);
    rst = 1'b0;
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (ia.rsp_valid != 2'b00 || ia.busy) bad = 1'b1;
    end
    chk("aborted_silent", bad, 1'b0);
    rr = 0;
    rnd(0); rnd(1);
    txn(2'b11, 0);
    ia.req_valid = 2'b00;

    // watchdog: done never arrives
    ib.req_key[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    ib.req_block[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    ib.req_valid = 2'b01;
    #1;
    chk("wd_req_ready", ib.req_ready, 2'b01);
    @(negedge clk);
    ib.req_valid = 2'b00;
    chk("wd_core_start", ib.core_start, 1'b1);
    lat = 0;
    while (ib.rsp_valid == 2'b00 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("wd_latency", lat, 8);
    chk("wd_rsp_valid", ib.rsp_valid, 2'b01);
    chk("wd_rsp_err", ib.rsp_err, 1'b1);
    chk("wd_rsp_data", ib.rsp_data, '0);
    ib.core_result = {$urandom(), $urandom(), $urandom(), $urandom()};
    ib.core_done = 1'b1;
    repeat (2) @(negedge clk);
    ib.core_done = 1'b0;
    chk("late_done_valid", ib.rsp_valid, 2'b01);
    chk("late_done_err", ib.rsp_err, 1'b1);
    chk("late_done_data", ib.rsp_data, '0);
    ib.rsp_ready = 2'b01;
    @(negedge clk);
    ib.rsp_ready = 2'b00;
    chk("wd_idle", ib.busy, 1'b0);

    // stale done in START ignored; done in the expiry cycle wins
    ib.req_valid = 2'b10;
    #1;
    chk("b_req_ready", ib.req_ready, 2'b10);
    @(negedge clk);
    ib.req_valid = 2'b00;
    ib.core_done = 1'b1;
    @(negedge clk);
    ib.core_done = 1'b0;
    chk("stale_done", ib.rsp_valid, 2'b00);
    repeat (5) @(negedge clk);
    chk("no_early_timeout", ib.rsp_valid, 2'b00);
    @(negedge clk);
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    ib.core_result = r;
    ib.core_done = 1'b1;
    @(negedge clk);
    ib.core_done = 1'b0;
    chk("edge_rsp_valid", ib.rsp_valid, 2'b10);
    chk("edge_rsp_err", ib.rsp_err, 1'b0);
    chk("edge_rsp_data", ib.rsp_data, r);
    ib.rsp_ready = 2'b10;
    @(negedge clk);
    ib.rsp_ready = 2'b00;
    chk("edge_idle", ib.busy, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
